// File: rtl/wb_sdram_whitebox_mon_if.sv
// Bus bundle observed by the whitebox monitor: the Wishbone slave-port
// signals and the decoded SDRAM command pins. The master modport is the
// side that drives the wires. The slave modport is the passive monitor
// view and has inputs only.
interface wb_sdram_whitebox_mon_if #(
  parameter int AW = 26,
  parameter int DW = 32
);
  localparam int SW = DW / 8;

  logic          wb_cyc_i;
  logic          wb_stb_i;
  logic          wb_we_i;
  logic          wb_ack_o;
  logic [AW-1:0] wb_addr_i;
  logic [SW-1:0] wb_sel_i;
  logic [2:0]    wb_cti_i;
  logic          sdram_en;
  logic          sdram_ras_n;
  logic          sdram_cas_n;
  logic          sdram_we_n;

  modport master (
    output wb_cyc_i, wb_stb_i, wb_we_i, wb_ack_o, wb_addr_i, wb_sel_i, wb_cti_i,
    output sdram_en, sdram_ras_n, sdram_cas_n, sdram_we_n
  );

  modport slave (
    input wb_cyc_i, wb_stb_i, wb_we_i, wb_ack_o, wb_addr_i, wb_sel_i, wb_cti_i,
    input sdram_en, sdram_ras_n, sdram_cas_n, sdram_we_n
  );
endinterface

// File: rtl/wb_sdram_whitebox_mon.sv
// Passive whitebox monitor for the SDRAM controller's Wishbone port and
// SDRAM command pins. It counts beats, bursts and SDRAM commands, and it
// measures first-beat ack latency. It also raises sticky protocol-error
// flags. The monitor drives no bus signal.
module wb_sdram_whitebox_mon #(
  parameter int AW      = 26,
  parameter int DW      = 32,
  parameter int CNT_W   = 32,
  parameter int LAT_W   = 16,
  parameter int TIMEOUT = 256
) (
  input  logic                 wb_clk_i,
  input  logic                 wb_rst_i,
  input  logic                 clr_i,
  wb_sdram_whitebox_mon_if.slave bus,
  output logic [CNT_W-1:0]     rd_cnt,
  output logic [CNT_W-1:0]     wr_cnt,
  output logic [CNT_W-1:0]     burst_cnt,
  output logic [CNT_W-1:0]     act_cnt,
  output logic [CNT_W-1:0]     rd_cmd_cnt,
  output logic [CNT_W-1:0]     wr_cmd_cnt,
  output logic [CNT_W-1:0]     pre_cnt,
  output logic [CNT_W-1:0]     ref_cnt,
  output logic [LAT_W-1:0]     lat_last,
  output logic [LAT_W-1:0]     lat_max,
  output logic                 lat_valid,
  output logic [3:0]           err_flags,
  output logic [AW-1:0]        err_addr
);
  localparam int SW   = DW / 8;
  localparam int N_EV = 8;

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] WAIT  = 2'd1;
  localparam logic [1:0] BURST = 2'd2;

  // The count at which a stalled first beat is declared timed out.
  localparam logic [LAT_W-1:0] TO_VAL = LAT_W'(TIMEOUT);

  logic             req;
  logic             beat;
  logic [2:0]       sd_cmd;
  logic [N_EV-1:0]  ev;
  logic [1:0]       state_reg;
  logic [LAT_W-1:0] lat_cnt_reg;
  logic [LAT_W-1:0] lat_inc;
  logic [LAT_W-1:0] lat_last_reg;
  logic [LAT_W-1:0] lat_max_reg;
  logic             lat_valid_reg;
  logic [AW-1:0]    addr_reg;
  logic             we_reg;
  logic [SW-1:0]    sel_reg;
  logic             chg;
  logic             timeout_hit;
  logic [3:0]       err_now;
  logic [3:0]       err_flags_reg;
  logic [AW-1:0]    err_addr_reg;

  assign req    = bus.wb_cyc_i & bus.wb_stb_i;
  assign beat   = req & bus.wb_ack_o;
  assign sd_cmd = {bus.sdram_ras_n, bus.sdram_cas_n, bus.sdram_we_n};

  // The latency count saturates instead of wrapping.
  assign lat_inc = (lat_cnt_reg == '1) ? lat_cnt_reg : lat_cnt_reg + LAT_W'(1);

  // The request changed underneath a stalled first beat.
  assign chg = (state_reg == WAIT) & req & ~bus.wb_ack_o &
               ((bus.wb_addr_i != addr_reg) | (bus.wb_we_i != we_reg) |
                (bus.wb_sel_i != sel_reg));

  // The stall would reach the limit this cycle, with no ack in sight.
  assign timeout_hit = (state_reg == WAIT) & req & ~bus.wb_ack_o & (lat_inc >= TO_VAL);

  assign err_now = {bus.wb_stb_i & ~bus.wb_cyc_i, chg, timeout_hit, bus.wb_ack_o & ~req};

  // Per-cycle event strobes. Index order matches the counter outputs below.
  always_comb begin
    ev    = '0;
    ev[0] = beat & ~bus.wb_we_i;
    ev[1] = beat & bus.wb_we_i;
    ev[2] = beat & (bus.wb_cti_i == 3'b111);
    if (bus.sdram_en) begin
      ev[3] = (sd_cmd == 3'b011);
      ev[4] = (sd_cmd == 3'b101);
      ev[5] = (sd_cmd == 3'b100);
      ev[6] = (sd_cmd == 3'b010);
      ev[7] = (sd_cmd == 3'b001);
    end
  end

  // One saturating event counter per strobe. Clear takes priority over a
  // coincident event.
  generate
    for (genvar gi = 0; gi < N_EV; gi++) begin : g_cnt
      logic [CNT_W-1:0] cnt_reg;
      // Count the event and hold at all-ones.
      always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i || clr_i) begin
          cnt_reg <= '0;
        end else if (ev[gi] && (cnt_reg != '1)) begin
          cnt_reg <= cnt_reg + CNT_W'(1);
        end
      end
    end
  endgenerate

  assign rd_cnt     = g_cnt[0].cnt_reg;
  assign wr_cnt     = g_cnt[1].cnt_reg;
  assign burst_cnt  = g_cnt[2].cnt_reg;
  assign act_cnt    = g_cnt[3].cnt_reg;
  assign rd_cmd_cnt = g_cnt[4].cnt_reg;
  assign wr_cmd_cnt = g_cnt[5].cnt_reg;
  assign pre_cnt    = g_cnt[6].cnt_reg;
  assign ref_cnt    = g_cnt[7].cnt_reg;

  // This FSM measures first-beat latency. It tracks the first beat, then
  // the rest of an incrementing burst, where no latency is measured.
  always_ff @(posedge wb_clk_i) begin
    lat_valid_reg <= 1'b0;
    if (wb_rst_i || clr_i) begin
      state_reg    <= IDLE;
      lat_cnt_reg  <= '0;
      lat_last_reg <= '0;
      lat_max_reg  <= '0;
      addr_reg     <= '0;
      we_reg       <= 1'b0;
      sel_reg      <= '0;
    end else begin
      case (state_reg)
        IDLE: begin
          if (req) begin
            if (bus.wb_ack_o) begin
              lat_last_reg  <= LAT_W'(1);
              lat_valid_reg <= 1'b1;
              if (lat_max_reg == '0) lat_max_reg <= LAT_W'(1);
            end else begin
              state_reg   <= WAIT;
              lat_cnt_reg <= LAT_W'(1);
              addr_reg    <= bus.wb_addr_i;
              we_reg      <= bus.wb_we_i;
              sel_reg     <= bus.wb_sel_i;
            end
          end
        end
        WAIT: begin
          if (!req) begin
            state_reg <= IDLE;
          end else if (bus.wb_ack_o) begin
            lat_last_reg  <= lat_inc;
            lat_valid_reg <= 1'b1;
            if (lat_inc > lat_max_reg) lat_max_reg <= lat_inc;
            state_reg <= (bus.wb_cti_i == 3'b010) ? BURST : IDLE;
          end else if (timeout_hit) begin
            state_reg <= IDLE;
          end else begin
            lat_cnt_reg <= lat_inc;
          end
        end
        BURST: begin
          if (!bus.wb_cyc_i || (beat && (bus.wb_cti_i == 3'b111))) state_reg <= IDLE;
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

  // Sticky error flags. The address is captured only on the first error.
  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i || clr_i) begin
      err_flags_reg <= '0;
      err_addr_reg  <= '0;
    end else begin
      err_flags_reg <= err_flags_reg | err_now;
      if ((err_flags_reg == '0) && (err_now != '0)) err_addr_reg <= bus.wb_addr_i;
    end
  end

  assign lat_last  = lat_last_reg;
  assign lat_max   = lat_max_reg;
  assign lat_valid = lat_valid_reg;
  assign err_flags = err_flags_reg;
  assign err_addr  = err_addr_reg;
endmodule

// File: tb/tb_wb_sdram_whitebox_mon.sv
// Self-checking bench for wb_sdram_whitebox_mon. The bench runs directed
// table vectors, hand sequences for timeout, latency and saturation cases,
// and a randomized run. Every cycle is also checked against a behavioural
// model of the monitoring rules.
module tb_wb_sdram_whitebox_mon;
  localparam int AW = 26, DW = 32, SW = DW / 8;
  localparam int CNT_W = 8, LAT_W = 16, TIMEOUT = 256;
  localparam int MAXC = (1 << CNT_W) - 1;

  logic clk = 1'b0;
  logic rst, clr;
  always #5 clk = ~clk;

  wb_sdram_whitebox_mon_if #(.AW(AW), .DW(DW)) bus ();

  logic [CNT_W-1:0] rd_cnt, wr_cnt, burst_cnt, act_cnt, rd_cmd_cnt, wr_cmd_cnt, pre_cnt, ref_cnt;
  logic [LAT_W-1:0] lat_last, lat_max;
  logic             lat_valid;
  logic [3:0]       err_flags;
  logic [AW-1:0]    err_addr;

  wb_sdram_whitebox_mon #(.AW(AW), .DW(DW), .CNT_W(CNT_W), .LAT_W(LAT_W), .TIMEOUT(TIMEOUT)) dut (
    .wb_clk_i(clk), .wb_rst_i(rst), .clr_i(clr), .bus(bus),
    .rd_cnt(rd_cnt), .wr_cnt(wr_cnt), .burst_cnt(burst_cnt), .act_cnt(act_cnt),
    .rd_cmd_cnt(rd_cmd_cnt), .wr_cmd_cnt(wr_cmd_cnt), .pre_cnt(pre_cnt), .ref_cnt(ref_cnt),
    .lat_last(lat_last), .lat_max(lat_max), .lat_valid(lat_valid),
    .err_flags(err_flags), .err_addr(err_addr)
  );

  int n_vec = 0;
  int n_err = 0;

  // Model state. Counter index order is rd, wr, burst, act, rdcmd, wrcmd, pre, ref.
  int            m_cnt [8];
  bit            m_pend, m_inburst, m_vld;
  int            m_wait, m_lat_last, m_lat_max;
  logic [AW-1:0] m_saddr, m_eaddr;
  logic          m_swe;
  logic [SW-1:0] m_ssel;
  logic [3:0]    m_err;

  task automatic chk(input string nm, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", nm, got, exp);
    end
  endtask

  task automatic bump(input int i);
    m_cnt[i] = (m_cnt[i] >= MAXC) ? MAXC : m_cnt[i] + 1;
  endtask

  task automatic report(input int lat);
    m_lat_last = lat;
    m_vld      = 1'b1;
    if (lat > m_lat_max) m_lat_max = lat;
  endtask

  // Apply the monitoring rules to the inputs sampled at this clock edge.
  task automatic model_step();
    logic req, beat;
    logic [3:0] errs;
    req  = bus.wb_cyc_i & bus.wb_stb_i;
    beat = req & bus.wb_ack_o;
    m_vld = 1'b0;
    if (rst || clr) begin
      foreach (m_cnt[i]) m_cnt[i] = 0;
      m_pend = 0; m_inburst = 0; m_wait = 0;
      m_lat_last = 0; m_lat_max = 0; m_err = '0; m_eaddr = '0;
      return;
    end
    if (beat) bump(bus.wb_we_i ? 1 : 0);
    if (beat && bus.wb_cti_i == 3'b111) bump(2);
    if (bus.sdram_en) begin
      case ({bus.sdram_ras_n, bus.sdram_cas_n, bus.sdram_we_n})
        3'b011: bump(3);
        3'b101: bump(4);
        3'b100: bump(5);
        3'b010: bump(6);
        3'b001: bump(7);
        default: ;
      endcase
    end
    errs = '0;
    if (bus.wb_ack_o && !req) errs[0] = 1'b1;
    if (bus.wb_stb_i && !bus.wb_cyc_i) errs[3] = 1'b1;
    if (m_pend) begin
      if (!req) m_pend = 0;
      else if (bus.wb_ack_o) begin
        report(m_wait + 1);
        m_pend = 0;
        m_inburst = (bus.wb_cti_i == 3'b010);
      end else begin
        if (bus.wb_addr_i != m_saddr || bus.wb_we_i != m_swe || bus.wb_sel_i != m_ssel) errs[2] = 1'b1;
        m_wait++;
        if (m_wait >= TIMEOUT) begin
          errs[1] = 1'b1;
          m_pend = 0;
        end
      end
    end else if (m_inburst) begin
      if (!bus.wb_cyc_i || (beat && bus.wb_cti_i == 3'b111)) m_inburst = 0;
    end else if (req) begin
      if (bus.wb_ack_o) report(1);
      else begin
        m_pend = 1; m_wait = 1;
        m_saddr = bus.wb_addr_i; m_swe = bus.wb_we_i; m_ssel = bus.wb_sel_i;
      end
    end
    if (errs != 0 && m_err == 0) m_eaddr = bus.wb_addr_i;
    m_err |= errs;
  endtask

  task automatic check_model();
    chk("m_rd_cnt", rd_cnt, m_cnt[0]);
    chk("m_wr_cnt", wr_cnt, m_cnt[1]);
    chk("m_burst_cnt", burst_cnt, m_cnt[2]);
    chk("m_act_cnt", act_cnt, m_cnt[3]);
    chk("m_rd_cmd_cnt", rd_cmd_cnt, m_cnt[4]);
    chk("m_wr_cmd_cnt", wr_cmd_cnt, m_cnt[5]);
    chk("m_pre_cnt", pre_cnt, m_cnt[6]);
    chk("m_ref_cnt", ref_cnt, m_cnt[7]);
    chk("m_lat_last", lat_last, m_lat_last);
    chk("m_lat_max", lat_max, m_lat_max);
    chk("m_lat_valid", lat_valid, m_vld);
    chk("m_err_flags", err_flags, m_err);
    chk("m_err_addr", err_addr, m_eaddr);
  endtask

  // One clock: the model follows the sampled inputs, then the outputs are compared just after the edge.
  task automatic step();
    @(posedge clk);
    model_step();
    #1;
    check_model();
  endtask

  task automatic drive(input logic cyc, input logic stb, input logic we, input logic ack,
                       input logic [2:0] cti, input logic [AW-1:0] addr,
                       input logic en, input logic [2:0] cmd);
    bus.wb_cyc_i = cyc; bus.wb_stb_i = stb; bus.wb_we_i = we; bus.wb_ack_o = ack;
    bus.wb_cti_i = cti; bus.wb_addr_i = addr;
    bus.sdram_en = en;
    {bus.sdram_ras_n, bus.sdram_cas_n, bus.sdram_we_n} = cmd;
  endtask

  typedef struct {
    logic cyc, stb, we, ack, en, clr;
    logic [2:0] cti, cmd;
    logic [AW-1:0] addr;
    int rd, wr, bst, lat, vld, err, act, rdc, wrc, pre, rf;
    logic [AW-1:0] eaddr;
  } vec_t;
  vec_t tbl[$];

  task automatic add(input logic cyc, stb, we, ack, input logic [2:0] cti, input logic [AW-1:0] addr,
                     input logic en, input logic [2:0] cmd, input logic c,
                     input int rd, wr, bst, lat, vld, err, input int cmds, input logic [AW-1:0] eaddr);
    vec_t v;
    v.cyc = cyc; v.stb = stb; v.we = we; v.ack = ack; v.cti = cti; v.addr = addr;
    v.en = en; v.cmd = cmd; v.clr = c;
    v.rd = rd; v.wr = wr; v.bst = bst; v.lat = lat; v.vld = vld; v.err = err;
    v.act = (cmds >> 16) & 15; v.rdc = (cmds >> 12) & 15; v.wrc = (cmds >> 8) & 15;
    v.pre = (cmds >> 4) & 15; v.rf = cmds & 15;
    v.eaddr = eaddr;
    tbl.push_back(v);
  endtask

  initial begin
    logic [AW-1:0] a;
    logic [2:0] ctis [3];
    ctis[0] = 3'b000; ctis[1] = 3'b010; ctis[2] = 3'b111;
    bus.wb_sel_i = 4'hF;
    clr = 1'b0;
    rst = 1'b1;
    drive(0, 0, 0, 0, 3'b000, '0, 0, 3'b111);
    step();
    step();
    chk("reset_rd_cnt", rd_cnt, 0);
    chk("reset_act_cnt", act_cnt, 0);
    chk("reset_lat_last", lat_last, 0);
    chk("reset_lat_valid", lat_valid, 0);
    chk("reset_err_flags", err_flags, 0);
    chk("reset_err_addr", err_addr, 0);
    rst = 1'b0;

    // Directed vectors: the cmds column packs {act,rdc,wrc,pre,ref} as nibbles.
    for (int i = 0; i < 3; i++)
      add(1, 1, 0, 0, 3'b000, 'h100, 0, 3'b111, 0, 0, 0, 0, 0, 0, 0, 'h00000, 0);
    add(1, 1, 0, 1, 3'b000, 'h100, 0, 3'b111, 0, 1, 0, 0, 4, 1, 0, 'h00000, 0);
    add(0, 0, 0, 0, 3'b000, 'h000, 0, 3'b111, 0, 1, 0, 0, 4, 0, 0, 'h00000, 0);
    add(0, 0, 0, 0, 3'b000, 'h000, 1, 3'b011, 0, 1, 0, 0, 4, 0, 0, 'h10000, 0);
    add(0, 0, 0, 0, 3'b000, 'h000, 1, 3'b100, 0, 1, 0, 0, 4, 0, 0, 'h10100, 0);
    add(0, 0, 0, 0, 3'b000, 'h000, 1, 3'b101, 0, 1, 0, 0, 4, 0, 0, 'h11100, 0);
    add(0, 0, 0, 0, 3'b000, 'h000, 1, 3'b010, 0, 1, 0, 0, 4, 0, 0, 'h11110, 0);
    add(0, 0, 0, 0, 3'b000, 'h000, 1, 3'b001, 0, 1, 0, 0, 4, 0, 0, 'h11111, 0);
    add(0, 0, 0, 0, 3'b000, 'h000, 0, 3'b011, 0, 1, 0, 0, 4, 0, 0, 'h11111, 0);
    add(0, 0, 0, 0, 3'b000, 'h000, 0, 3'b100, 0, 1, 0, 0, 4, 0, 0, 'h11111, 0);
    add(0, 0, 0, 0, 3'b000, 'h000, 0, 3'b101, 0, 1, 0, 0, 4, 0, 0, 'h11111, 0);
    add(0, 0, 0, 0, 3'b000, 'h000, 0, 3'b010, 0, 1, 0, 0, 4, 0, 0, 'h11111, 0);
    add(0, 0, 0, 0, 3'b000, 'h000, 0, 3'b001, 0, 1, 0, 0, 4, 0, 0, 'h11111, 0);
    add(0, 0, 0, 0, 3'b000, 'h000, 1, 3'b110, 0, 1, 0, 0, 4, 0, 0, 'h11111, 0);
    add(0, 0, 0, 0, 3'b000, 'h000, 1, 3'b000, 0, 1, 0, 0, 4, 0, 0, 'h11111, 0);
    add(0, 0, 0, 0, 3'b000, 'h000, 1, 3'b111, 0, 1, 0, 0, 4, 0, 0, 'h11111, 0);
    // Incrementing burst of 8 writes. The first beat has latency 2.
    add(1, 1, 1, 0, 3'b010, 'h200, 0, 3'b111, 0, 1, 0, 0, 4, 0, 0, 'h11111, 0);
    add(1, 1, 1, 1, 3'b010, 'h200, 0, 3'b111, 0, 1, 1, 0, 2, 1, 0, 'h11111, 0);
    for (int i = 2; i <= 7; i++)
      add(1, 1, 1, 1, 3'b010, AW'('h200 + 4 * (i - 1)), 0, 3'b111, 0, 1, i, 0, 2, 0, 0, 'h11111, 0);
    add(1, 1, 1, 1, 3'b111, 'h21C, 0, 3'b111, 0, 1, 8, 1, 2, 0, 0, 'h11111, 0);
    add(0, 0, 0, 0, 3'b000, 'h000, 0, 3'b111, 0, 1, 8, 1, 2, 0, 0, 'h11111, 0);
    // An ack without a request, then an address change during the wait.
    add(1, 0, 0, 1, 3'b000, 'h333, 0, 3'b111, 0, 1, 8, 1, 2, 0, 1, 'h11111, 'h333);
    add(1, 1, 0, 0, 3'b000, 'h400, 0, 3'b111, 0, 1, 8, 1, 2, 0, 1, 'h11111, 'h333);
    add(1, 1, 0, 0, 3'b000, 'h404, 0, 3'b111, 0, 1, 8, 1, 2, 0, 5, 'h11111, 'h333);
    add(0, 0, 0, 0, 3'b000, 'h000, 0, 3'b111, 0, 1, 8, 1, 2, 0, 5, 'h11111, 'h333);
    // A clear with a simultaneous beat and command leaves everything at zero.
    add(1, 1, 0, 1, 3'b000, 'h500, 1, 3'b011, 1, 0, 0, 0, 0, 0, 0, 'h00000, 0);
    add(0, 0, 0, 0, 3'b000, 'h000, 0, 3'b111, 0, 0, 0, 0, 0, 0, 0, 'h00000, 0);

    foreach (tbl[i]) begin
      drive(tbl[i].cyc, tbl[i].stb, tbl[i].we, tbl[i].ack, tbl[i].cti, tbl[i].addr, tbl[i].en, tbl[i].cmd);
      clr = tbl[i].clr;
      step();
      chk($sformatf("tbl%0d_rd_cnt", i), rd_cnt, tbl[i].rd);
      chk($sformatf("tbl%0d_wr_cnt", i), wr_cnt, tbl[i].wr);
      chk($sformatf("tbl%0d_burst_cnt", i), burst_cnt, tbl[i].bst);
      chk($sformatf("tbl%0d_lat_last", i), lat_last, tbl[i].lat);
      chk($sformatf("tbl%0d_lat_valid", i), lat_valid, tbl[i].vld);
      chk($sformatf("tbl%0d_err_flags", i), err_flags, tbl[i].err);
      chk($sformatf("tbl%0d_err_addr", i), err_addr, tbl[i].eaddr);
      chk($sformatf("tbl%0d_cmds", i), {act_cnt, rd_cmd_cnt, wr_cmd_cnt, pre_cnt, ref_cnt},
          {CNT_W'(tbl[i].act), CNT_W'(tbl[i].rdc), CNT_W'(tbl[i].wrc), CNT_W'(tbl[i].pre), CNT_W'(tbl[i].rf)});
      $display("vec %0d: cyc=%b stb=%b we=%b ack=%b cti=%b addr=%0h en=%b cmd=%b clr=%b -> rd=%0d wr=%0d lat=%0d err=%b",
               i, tbl[i].cyc, tbl[i].stb, tbl[i].we, tbl[i].ack, tbl[i].cti, tbl[i].addr, tbl[i].en,
               tbl[i].cmd, tbl[i].clr, rd_cnt, wr_cnt, lat_last, err_flags);
    end
    clr = 1'b0;

    // Timeout: the strobe is held for TIMEOUT cycles with no ack.
    drive(1, 1, 0, 0, 3'b000, 'h7A0, 0, 3'b111);
    for (int i = 0; i < TIMEOUT; i++) step();
    chk("to_err_flags", err_flags, 4'b0010);
    chk("to_err_addr", err_addr, 'h7A0);
    chk("to_lat_last", lat_last, 0);
    drive(0, 0, 0, 0, 3'b000, '0, 0, 3'b111);
    step();
    // The FSM must be back in IDLE, so a new read measures a fresh latency.
    drive(1, 1, 0, 0, 3'b000, 'h7B0, 0, 3'b111);
    step();
    drive(1, 1, 0, 1, 3'b000, 'h7B0, 0, 3'b111);
    step();
    chk("post_to_lat_last", lat_last, 2);
    chk("post_to_lat_valid", lat_valid, 1);
    $display("seq timeout: err=%b err_addr=%0h lat_last=%0d", err_flags, err_addr, lat_last);

    // Boundary: an ack on the last cycle before the timeout is still measured.
    clr = 1'b1;
    drive(0, 0, 0, 0, 3'b000, '0, 0, 3'b111);
    step();
    clr = 1'b0;
    drive(1, 1, 0, 0, 3'b000, 'h7C0, 0, 3'b111);
    for (int i = 0; i < TIMEOUT - 1; i++) step();
    drive(1, 1, 0, 1, 3'b000, 'h7C0, 0, 3'b111);
    step();
    chk("edge_lat_last", lat_last, TIMEOUT);
    chk("edge_lat_max", lat_max, TIMEOUT);
    chk("edge_err_flags", err_flags, 0);
    $display("seq edge: lat_last=%0d err=%b", lat_last, err_flags);

    // Saturation: drive more beats and ACTs than the counters can hold.
    drive(1, 1, 0, 1, 3'b000, 'h800, 1, 3'b011);
    for (int i = 0; i < MAXC + 5; i++) step();
    chk("sat_rd_cnt", rd_cnt, MAXC);
    chk("sat_act_cnt", act_cnt, MAXC);
    clr = 1'b1;
    step();
    clr = 1'b0;
    chk("satclr_rd_cnt", rd_cnt, 0);
    chk("satclr_act_cnt", act_cnt, 0);
    $display("seq saturation: rd=%0d act=%0d after clear", rd_cnt, act_cnt);

    // Randomized traffic, checked against the model every cycle.
    a = 'h900;
    for (int i = 0; i < 4000; i++) begin
      if ($urandom_range(0, 9) == 0) a = AW'($urandom_range(0, 15) * 4);
      bus.wb_cyc_i = ($urandom_range(0, 99) < 85);
      bus.wb_stb_i = bus.wb_cyc_i ? ($urandom_range(0, 9) < 7) : ($urandom_range(0, 19) == 0);
      bus.wb_ack_o = ($urandom_range(0, 9) < 4);
      bus.wb_cti_i = ctis[$urandom_range(0, 2)];
      bus.wb_addr_i = a;
      if ($urandom_range(0, 9) == 0) bus.wb_we_i = ~bus.wb_we_i;
      if ($urandom_range(0, 19) == 0) bus.wb_sel_i = SW'($urandom_range(0, 15));
      bus.sdram_en = ($urandom_range(0, 3) != 0);
      {bus.sdram_ras_n, bus.sdram_cas_n, bus.sdram_we_n} = 3'($urandom_range(0, 7));
      clr = ($urandom_range(0, 149) == 0);
      rst = ($urandom_range(0, 499) == 0);
      step();
    end
    rst = 1'b0;
    clr = 1'b0;
    $display("seq random: rd=%0d wr=%0d burst=%0d lat_max=%0d err=%b", rd_cnt, wr_cnt, burst_cnt, lat_max, err_flags);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
